imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DWIDTH, default 32, instruction width in bits; only 32 is supported.
REQ-002 Parameter IWIDTH, default 32, immediate output width; 32 or 64, sign/zero-extended to IWIDTH.
REQ-003 Parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried alongside each instruction.
REQ-004 Parameter ZICSR_EN, default 1; 1 = SYSTEM opcode decoded as CSR format, 0 = SYSTEM flagged illegal.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush_i  input  1  synchronous pipeline flush; discards all held entries.
REQ-008 in_valid_i  input  1  upstream has an instruction.
REQ-009 in_ready_o  output  1  block can accept an instruction this cycle.
REQ-010 opcode_i  input  7  opcode; used for decode, insn_i[6:0] ignored.
REQ-011 insn_i  input  DWIDTH  instruction word.
REQ-012 tag_i  input  TAG_W  sideband tag, passed through unmodified.
REQ-013 out_valid_o  output  1  output entry valid.
REQ-014 out_ready_i  input  1  downstream accepts the output entry.
REQ-015 imm_o  output  IWIDTH  generated immediate.
REQ-016 fmt_o  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, Z(CSR)=6.
REQ-017 illegal_o  output  1  opcode not recognised.
REQ-018 tag_o  output  TAG_W  tag of the output entry.

Function
REQ-019 Decode shall be: I for 0010011, 0000011, 1100111, 0001111; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111; R for 0110011 (imm 0).
REQ-020 I/S/B/J immediates shall be sign-extended from insn[31] to IWIDTH; B and J have bit0 = 0.
REQ-021 U immediate shall be {insn[31:12], 12'b0}, sign-extended from bit 31 when IWIDTH = 64.
REQ-022 SYSTEM (1110011) with ZICSR_EN=1: fmt Z; imm = zero-extended insn[19:15] when insn[14]=1, else zero-extended insn[31:20].
REQ-023 Any other opcode (or SYSTEM with ZICSR_EN=0) shall give imm 0, fmt R, illegal_o 1; the entry still flows through the pipe.
REQ-024 Latency shall be exactly 1 cycle: an entry accepted in cycle N is visible on outputs in cycle N+1 when the output stage is empty or draining.
REQ-025 Storage shall be a main output register plus one skid register (2 entries total); the decoded result is registered, not recomputed at the output.
REQ-026 in_ready_o shall be registered and equal to "skid register empty"; it shall not depend combinationally on out_ready_i.
REQ-027 Transfer shall occur on valid && ready on either side; out_valid_o, once high, shall stay high with all output fields stable until accepted or flushed.
REQ-028 When the main register is empty or draining, an accepted input shall load the main register; otherwise it shall load the skid register.
REQ-029 When the main register drains while the skid register is full, the skid entry shall move to the main register in the same cycle, and in_ready_o shall rise next cycle.
REQ-030 Order shall be preserved; no entry is dropped or duplicated with back-to-back traffic and arbitrary out_ready_i.
REQ-031 With both registers full, in_ready_o = 0 and no input is accepted.
REQ-032 flush_i shall clear both valid bits next cycle, set in_ready_o = 1, and drop any input presented in the same cycle (flush wins over a simultaneous accept).

Reset
REQ-033 While reset is high: out_valid_o = 0, in_ready_o = 0, imm_o = 0, fmt_o = 0, illegal_o = 0, tag_o = 0.
REQ-034 In the first cycle after reset deasserts, in_ready_o = 1; reset mid-stream discards all held entries, same as flush.
REQ-035 reset shall take priority over flush_i and all handshakes.

Verification
REQ-036 insn 0xFFF00093 (addi -1), out_ready_i=1 -> one cycle later imm_o 0xFFFFFFFF, fmt 1; with IWIDTH=64 imm_o 0xFFFFFFFFFFFFFFFF.
REQ-037 Sequence 0x00112623, 0xFE000EE3, 0x12345037, 0x0080006F back-to-back -> imm 0x0000000C/S, 0xFFFFFFFC/B, 0x12345000/U, 0x00000008/J, in order, one per cycle.
REQ-038 0x3002D073 (csrrwi) -> imm 5, fmt 6; same with ZICSR_EN=0 -> imm 0, fmt 0, illegal 1; opcode 1111111 -> illegal 1.
REQ-039 out_ready_i=0 for 4 cycles while in_valid_i=1 with tags 1,2,3 -> tags 1 and 2 held, in_ready_o low from the cycle after the second accept; release -> 1, 2, 3 emerge in order, none lost.
REQ-040 Both entries full, flush_i=1 together with in_valid_i=1 -> next cycle out_valid_o 0, in_ready_o 1, flushed input never emerges.
REQ-041 Reset asserted with both entries full -> out_valid_o 0 while reset is high; in_ready_o 1 in the first cycle after release.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
//   Handshake and data bundle for the immediate-generator pipe stage.
//   master : upstream/downstream driver (flush, input side, out_ready)
//   slave  : the pipe itself (in_ready, output entry fields)
//   Signals:
//     flush_i      synchronous flush of all held entries
//     in_valid_i   / in_ready_o    input handshake
//     opcode_i     7-bit opcode used for decode
//     insn_i       instruction word (DWIDTH bits)
//     tag_i        sideband tag carried with the instruction
//     out_valid_o  / out_ready_i   output handshake
//     imm_o        generated immediate (IWIDTH bits)
//     fmt_o        format code R=0 I=1 S=2 B=3 U=4 J=5 Z=6
//     illegal_o    opcode not recognised
//     tag_o        tag of the output entry
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 32,
  parameter int TAG_W  = 32
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [6:0]        opcode_i;
  logic [DWIDTH-1:0] insn_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [IWIDTH-1:0] imm_o;
  logic [2:0]        fmt_o;
  logic              illegal_o;
  logic [TAG_W-1:0]  tag_o;

  modport master (
    output flush_i, in_valid_i, opcode_i, insn_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );

  modport slave (
    input  flush_i, in_valid_i, opcode_i, insn_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   RISC-V immediate generator as a 1-cycle, 2-entry (main + skid) pipe
//   stage. Decode happens on the input side; the decoded result is stored,
//   so the output fields come straight from flops.
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous active-high reset (priority over everything)
//     bus    imm_gen_pipe_if.slave: flush, input and output handshakes
//   Parameters:
//     DWIDTH   instruction width (only 32 supported)
//     IWIDTH   immediate width, 32 or 64
//     TAG_W    sideband tag width
//     ZICSR_EN 1: SYSTEM decodes as CSR format, 0: SYSTEM is illegal
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int DWIDTH   = 32,
  parameter int IWIDTH   = 32,
  parameter int TAG_W    = 32,
  parameter bit ZICSR_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [IWIDTH-1:0] imm;
    fmt_e              fmt;
    logic              illegal;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  // -------------------------------------------------------------------------
  // Decode (input side)
  // -------------------------------------------------------------------------
  logic [31:7] ib;
  logic        unused_opc_bits;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic        sign;
  entry_t      dec;

  assign ib = bus.insn_i[31:7];
  // The opcode is taken from opcode_i; the low instruction bits are ignored.
  assign unused_opc_bits = ^bus.insn_i[6:0];

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    imm32       = '0;
    sign        = 1'b0;
    dec         = '0;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    dec.tag     = bus.tag_i;
    case (bus.opcode_i)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
        dec.fmt = FMT_I;
        imm32   = {{20{ib[31]}}, ib[31:20]};
        sign    = ib[31];
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{ib[31]}}, ib[31:25], ib[11:7]};
        sign    = ib[31];
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
        sign    = ib[31];
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {ib[31:12], 12'b0};
        sign    = ib[31];
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
        sign    = ib[31];
      end
      7'b0110011: dec.fmt = FMT_R;
      7'b1110011: begin
        if (ZICSR_EN) begin
          dec.fmt = FMT_Z;
          // Immediate-form CSR ops carry a 5-bit uimm in the rs1 field;
          // register forms expose the CSR address instead. Both zero-extend.
          imm32   = ib[14] ? {27'b0, ib[19:15]} : {20'b0, ib[31:20]};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Extend to 64 once, then keep the low IWIDTH bits (works for 32 and 64).
    imm64   = {{32{sign}}, imm32};
    dec.imm = imm64[IWIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // Main + skid storage control
  // -------------------------------------------------------------------------
  entry_t main_q, skid_q;
  logic   main_valid, skid_valid, in_ready_q;
  logic   main_valid_d, skid_valid_d;
  logic   ld_main_skid, ld_main_in, ld_skid;
  logic   main_free, in_fire;

  // in_ready_q tracks "skid empty" as a flop, so acceptance never depends
  // combinationally on out_ready_i. Flush cancels a same-cycle accept.
  assign in_fire   = bus.in_valid_i & in_ready_q & ~bus.flush_i;
  assign main_free = ~main_valid | bus.out_ready_i;

  always_comb begin
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    ld_main_skid = 1'b0;
    ld_main_in   = 1'b0;
    ld_skid      = 1'b0;
    if (main_free) begin
      // Older skid entry always goes first to preserve order.
      if (skid_valid) begin
        ld_main_skid = 1'b1;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        ld_main_in   = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      ld_skid      = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
      main_q     <= '0;
    end else if (bus.flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready_q <= ~skid_valid_d;
      if (ld_main_skid)    main_q <= skid_q;
      else if (ld_main_in) main_q <= dec;
    end
  end

  // NOTE: skid data has no reset; it is only ever observed through main_q
  // after skid_valid qualifies it, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (ld_skid) skid_q <= dec;
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = main_valid;
  assign bus.imm_o       = main_q.imm;
  assign bus.fmt_o       = main_q.fmt;
  assign bus.illegal_o   = main_q.illegal;
  assign bus.tag_o       = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. Two instances share one stimulus:
//   dut   : IWIDTH=32, ZICSR_EN=1
//   dut64 : IWIDTH=64, ZICSR_EN=0
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge following the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, in_valid, out_ready;
  logic [6:0]  opcode;
  logic [31:0] insn, tag;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.DWIDTH(32), .IWIDTH(32), .TAG_W(32)) bus   ();
  imm_gen_pipe_if #(.DWIDTH(32), .IWIDTH(64), .TAG_W(32)) bus64 ();

  assign bus.flush_i       = flush;
  assign bus.in_valid_i    = in_valid;
  assign bus.opcode_i      = opcode;
  assign bus.insn_i        = insn;
  assign bus.tag_i         = tag;
  assign bus.out_ready_i   = out_ready;
  assign bus64.flush_i     = flush;
  assign bus64.in_valid_i  = in_valid;
  assign bus64.opcode_i    = opcode;
  assign bus64.insn_i      = insn;
  assign bus64.tag_i       = tag;
  assign bus64.out_ready_i = out_ready;

  imm_gen_pipe #(.DWIDTH(32), .IWIDTH(32), .TAG_W(32), .ZICSR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  imm_gen_pipe #(.DWIDTH(32), .IWIDTH(64), .TAG_W(32), .ZICSR_EN(1'b0)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64)
  );

  typedef struct {
    logic [6:0]  op;
    logic [31:0] insn;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [31:0] ins, input logic [31:0] tg);
    in_valid = v;
    opcode   = op;
    insn     = ins;
    tag      = tg;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 7'h00, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.fmt_o, bus.illegal_o, bus.tag_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h, required all zero",
               bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.fmt_o, bus.illegal_o, bus.tag_o);
    end
    tests_run++;
    if ({bus64.out_valid_o, bus64.in_ready_o, bus64.imm_o, bus64.tag_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs64: valid=%b ready=%b imm=%h tag=%h, required all zero",
               bus64.out_valid_o, bus64.in_ready_o, bus64.imm_o, bus64.tag_o);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0",
               bus.in_ready_o, bus.out_valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_decode();
    vec_t v[8];
    v[0] = '{7'h13, 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    v[1] = '{7'h33, 32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
    v[2] = '{7'h73, 32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h0, 3'd0, 1'b1};
    v[3] = '{7'h73, 32'h30002073, 32'h00000300, 3'd6, 1'b0, 64'h0, 3'd0, 1'b1};
    v[4] = '{7'h7F, 32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
    // opcode_i says I-type although insn[6:0] is 1111111
    v[5] = '{7'h13, 32'h7FF0007F, 32'h000007FF, 3'd1, 1'b0, 64'h7FF, 3'd1, 1'b0};
    v[6] = '{7'h37, 32'h80000037, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    v[7] = '{7'h63, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v[i].op, v[i].insn, 32'd100 + i);
      @(negedge clk);
      drive(1'b0, 7'h00, 32'h0, 32'h0);
      tests_run++;
      if ({bus.out_valid_o, bus.imm_o, bus.fmt_o, bus.illegal_o, bus.tag_o} !==
          {1'b1, v[i].imm32, v[i].fmt32, v[i].ill32, 32'd100 + i}) begin
        tests_failed++;
        $display("FAIL decode32[%0d]: valid=%b imm=%h fmt=%0d ill=%b tag=%0d, required 1 %h %0d %b %0d",
                 i, bus.out_valid_o, bus.imm_o, bus.fmt_o, bus.illegal_o, bus.tag_o,
                 v[i].imm32, v[i].fmt32, v[i].ill32, 100 + i);
      end
      tests_run++;
      if ({bus64.out_valid_o, bus64.imm_o, bus64.fmt_o, bus64.illegal_o} !==
          {1'b1, v[i].imm64, v[i].fmt64, v[i].ill64}) begin
        tests_failed++;
        $display("FAIL decode64[%0d]: valid=%b imm=%h fmt=%0d ill=%b, required 1 %h %0d %b",
                 i, bus64.out_valid_o, bus64.imm_o, bus64.fmt_o, bus64.illegal_o,
                 v[i].imm64, v[i].fmt64, v[i].ill64);
      end
      @(negedge clk);
      tests_run++;
      if (bus.out_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL decode_drain[%0d]: valid=%b, required 0", i, bus.out_valid_o);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [31:0] ins[4]   = '{32'h00112623, 32'hFE000EE3, 32'h12345037, 32'h0080006F};
    logic [31:0] e32[4]   = '{32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};
    logic [63:0] e64[4]   = '{64'hC, 64'hFFFFFFFFFFFFFFFC, 64'h12345000, 64'h8};
    logic [2:0]  efmt[4]  = '{3'd2, 3'd3, 3'd4, 3'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i][6:0], ins[i], 32'd200 + i);
      @(negedge clk);
      tests_run++;
      if ({bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.fmt_o, bus.tag_o} !==
          {2'b11, e32[i], efmt[i], 32'd200 + i}) begin
        tests_failed++;
        $display("FAIL b2b32[%0d]: valid=%b ready=%b imm=%h fmt=%0d tag=%0d, required 1 1 %h %0d %0d",
                 i, bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.fmt_o, bus.tag_o,
                 e32[i], efmt[i], 200 + i);
      end
      tests_run++;
      if ({bus64.out_valid_o, bus64.imm_o, bus64.fmt_o} !== {1'b1, e64[i], efmt[i]}) begin
        tests_failed++;
        $display("FAIL b2b64[%0d]: valid=%b imm=%h fmt=%0d, required 1 %h %0d",
                 i, bus64.out_valid_o, bus64.imm_o, bus64.fmt_o, e64[i], efmt[i]);
      end
    end
    drive(1'b0, 7'h00, 32'h0, 32'h0);
    @(negedge clk);
    tests_run++;
    if (bus.out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: valid=%b, required 0", bus.out_valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_backpressure();
    // expected {out_valid, in_ready, imm, tag} at each sample point
    logic [65:0] exp_s[6];
    exp_s[0] = {2'b11, 32'd1, 32'd1};  // tag1 in main, skid empty
    exp_s[1] = {2'b10, 32'd1, 32'd1};  // tag2 in skid, ready drops
    exp_s[2] = {2'b10, 32'd1, 32'd1};  // stalled, tag3 waiting
    exp_s[3] = {2'b10, 32'd1, 32'd1};  // stalled, tag3 waiting
    exp_s[4] = {2'b11, 32'd2, 32'd2};  // released: skid moved up
    exp_s[5] = {2'b11, 32'd3, 32'd3};  // tag3 accepted and shown
    out_ready = 1'b0;
    drive(1'b1, 7'h13, 32'h00100093, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, 7'h13, 32'h00200093, 32'd2);
      if (i == 1) drive(1'b1, 7'h13, 32'h00300093, 32'd3);
      if (i == 3) out_ready = 1'b1;
      if (i == 5) drive(1'b0, 7'h00, 32'h0, 32'h0);
      tests_run++;
      if ({bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.tag_o} !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL backpressure[%0d]: valid=%b ready=%b imm=%h tag=%0d, required %b %b %h %0d",
                 i, bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.tag_o,
                 exp_s[i][65], exp_s[i][64], exp_s[i][63:32], exp_s[i][31:0]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_end: valid=%b, required 0 (duplicate entry)", bus.out_valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush();
    // Main full, skid empty: flush must still drop the accepted-looking input.
    out_ready = 1'b0;
    drive(1'b1, 7'h13, 32'h00500093, 32'h50);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 7'h13, 32'h00600093, 32'h66);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 7'h00, 32'h0, 32'h0);
    tests_run++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_main: valid=%b ready=%b, required 0 1", bus.out_valid_o, bus.in_ready_o);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_main_drop: valid=%b tag=%h, required valid 0", bus.out_valid_o, bus.tag_o);
    end

    // Both entries full, flush with a simultaneous input.
    out_ready = 1'b0;
    drive(1'b1, 7'h13, 32'h00100093, 32'h51);
    @(negedge clk);
    drive(1'b1, 7'h13, 32'h00200093, 32'h52);
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid_o, bus.in_ready_o, bus.tag_o} !== {2'b10, 32'h51}) begin
      tests_failed++;
      $display("FAIL flush_fill: valid=%b ready=%b tag=%h, required 1 0 51",
               bus.out_valid_o, bus.in_ready_o, bus.tag_o);
    end
    flush = 1'b1;
    drive(1'b1, 7'h13, 32'h00700093, 32'h77);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 7'h00, 32'h0, 32'h0);
    tests_run++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_full: valid=%b ready=%b, required 0 1", bus.out_valid_o, bus.in_ready_o);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_full_drop[%0d]: valid=%b tag=%h, required valid 0",
                 i, bus.out_valid_o, bus.tag_o);
      end
    end
    drive(1'b1, 7'h13, 32'h00800093, 32'h88);
    @(negedge clk);
    drive(1'b0, 7'h00, 32'h0, 32'h0);
    tests_run++;
    if ({bus.out_valid_o, bus.imm_o, bus.tag_o} !== {1'b1, 32'd8, 32'h88}) begin
      tests_failed++;
      $display("FAIL flush_recover: valid=%b imm=%h tag=%h, required 1 00000008 88",
               bus.out_valid_o, bus.imm_o, bus.tag_o);
    end
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 7'h13, 32'h00100093, 32'h91);
    @(negedge clk);
    drive(1'b1, 7'h13, 32'h00200093, 32'h92);
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_fill: valid=%b ready=%b, required 1 0", bus.out_valid_o, bus.in_ready_o);
    end
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 7'h13, 32'h00300093, 32'h93);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.tag_o} !== '0) begin
        tests_failed++;
        $display("FAIL rst_hold[%0d]: valid=%b ready=%b imm=%h tag=%h, required all zero",
                 i, bus.out_valid_o, bus.in_ready_o, bus.imm_o, bus.tag_o);
      end
    end
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 7'h00, 32'h0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_release: valid=%b ready=%b, required 0 1", bus.out_valid_o, bus.in_ready_o);
    end
    @(negedge clk);
    tests_run++;
    if (bus.out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_drop: valid=%b tag=%h, required valid 0", bus.out_valid_o, bus.tag_o);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
